// File: rtl/multi_bus_arbiter_pkg.sv
// Shared definitions for the multi-master bus arbiter: state encoding,
// arbitration-mode constants and a minimum-1-bit clog2 helper.
package arb_pkg;

    // Arbiter state encoding
    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // RR_MODE parameter values
    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Bits needed to index v items; never returns less than 1
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/multi_bus_arbiter_rr_pick.sv
// Rotating priority encoder: returns the first requester found when
// searching from ptr upward with wrap. With rr_en low, the search
// starts at 0, which gives plain fixed priority.
module arb_rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic            rr_en,
    output logic [ID_W-1:0] win_id,
    output logic            any_req
);

    logic [ID_W-1:0] base;
    logic [ID_W-1:0] cand [N];

    assign base    = rr_en ? ptr : '0;
    assign any_req = |req;

    // Candidate index for each search offset, wrapped explicitly at N-1 so
    // unused codes are never produced when N is not a power of two.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            logic [ID_W:0] sum;
            assign sum = {1'b0, base} + (ID_W+1)'(gi);
            assign cand[gi] = (sum >= (ID_W+1)'(N)) ? ID_W'(sum - (ID_W+1)'(N))
                                                     : ID_W'(sum);
        end
    endgenerate

    // Scan from the farthest offset back so the nearest requester wins
    always_comb begin
        win_id = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[cand[i]]) begin
                win_id = cand[i];
            end
        end
    end

endmodule

// File: rtl/multi_bus_arbiter.sv
// N-master bus arbiter with fixed-priority or round-robin selection,
// locked-burst hold with optional timeout, and park-on-last-owner.
// Grants decode straight from the owner register.
module multi_bus_arbiter
    import arb_pkg::*;
#(
    parameter  int NUM_MASTERS = 4,
    parameter  int RR_MODE     = 1,
    parameter  int MAX_HOLD    = 16,
    parameter  int PARK_ID     = 0,
    localparam int ID_W        = clog2_min1(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [NUM_MASTERS-1:0] lock,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [ID_W-1:0]        grant_id,
    output logic                   busy,
    output logic                   hold_timeout
);

    localparam int            CNT_W    = clog2_min1(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

    logic [ID_W-1:0]  owner_q, owner_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [0:0]       st_q, st_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             hold_timeout_q, hold_timeout_d;

    logic [ID_W-1:0]  win_id;
    logic             any_req;

    // Index following x, wrapping at the last master
    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] x);
        return (x == ID_W'(NUM_MASTERS - 1)) ? '0 : x + ID_W'(1);
    endfunction

    arb_rr_pick #(
        .N    (NUM_MASTERS),
        .ID_W (ID_W)
    ) u_pick (
        .req     (req),
        .ptr     (rr_ptr_q),
        .rr_en   (RR_MODE == ARB_RR),
        .win_id  (win_id),
        .any_req (any_req)
    );

    // Next-state: arbitrate in ARB, freeze owner and count in HOLD
    always_comb begin
        owner_d        = owner_q;
        rr_ptr_d       = rr_ptr_q;
        st_d           = st_q;
        hold_cnt_d     = hold_cnt_q;
        hold_timeout_d = 1'b0;
        if (st_q == ST_HOLD) begin
            if (!lock[owner_q] || !req[owner_q]) begin
                st_d       = ST_ARB;
                hold_cnt_d = '0;
            end else if ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_LIM)) begin
                // Forced release: move the pointer past the owner so it
                // cannot recapture the bus straight away.
                st_d           = ST_ARB;
                hold_cnt_d     = '0;
                hold_timeout_d = 1'b1;
                rr_ptr_d       = next_id(owner_q);
            end else if (hold_cnt_q != '1) begin
                hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
        end else if (any_req) begin
            owner_d = win_id;
            if (RR_MODE == ARB_RR) begin
                rr_ptr_d = next_id(win_id);
            end
            if (lock[win_id]) begin
                st_d       = ST_HOLD;
                hold_cnt_d = CNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q        <= ID_W'(PARK_ID);
            rr_ptr_q       <= '0;
            st_q           <= ST_ARB;
            hold_cnt_q     <= '0;
            hold_timeout_q <= 1'b0;
        end else begin
            owner_q        <= owner_d;
            rr_ptr_q       <= rr_ptr_d;
            st_q           <= st_d;
            hold_cnt_q     <= hold_cnt_d;
            hold_timeout_q <= hold_timeout_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_grant
            assign grant[gi] = (owner_q == ID_W'(gi));
        end
    endgenerate

    assign grant_id     = owner_q;
    assign busy         = req[owner_q];
    assign hold_timeout = hold_timeout_q;

endmodule

// File: tb/tb_multi_bus_arbiter.sv
// Directed bench for multi_bus_arbiter: three instances (4-master RR,
// 4-master fixed with unlimited hold, 3-master RR with MAX_HOLD=4).
// Expected owners are queued as stimulus is driven and checked after
// each rising edge.
module tb_multi_bus_arbiter;
    import arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0] req_a, lock_a, grant_a;
    logic [1:0] id_a;
    logic       busy_a, to_a;

    logic [3:0] req_b, lock_b, grant_b;
    logic [1:0] id_b;
    logic       busy_b, to_b;

    logic [2:0] req_c, lock_c, grant_c;
    logic [1:0] id_c;
    logic       busy_c, to_c;

    multi_bus_arbiter #(.NUM_MASTERS(4), .RR_MODE(ARB_RR), .MAX_HOLD(16), .PARK_ID(0)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .lock(lock_a),
        .grant(grant_a), .grant_id(id_a), .busy(busy_a), .hold_timeout(to_a));

    multi_bus_arbiter #(.NUM_MASTERS(4), .RR_MODE(ARB_FIXED), .MAX_HOLD(0), .PARK_ID(0)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .lock(lock_b),
        .grant(grant_b), .grant_id(id_b), .busy(busy_b), .hold_timeout(to_b));

    multi_bus_arbiter #(.NUM_MASTERS(3), .RR_MODE(ARB_RR), .MAX_HOLD(4), .PARK_ID(0)) dut_c (
        .clk(clk), .rst(rst), .req(req_c), .lock(lock_c),
        .grant(grant_c), .grant_id(id_c), .busy(busy_c), .hold_timeout(to_c));

    typedef struct {
        int         dut;
        logic [1:0] id;
        logic       to;
        logic       busy;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_assert = 0;
    int    n_fail   = 0;

    // Queue the expected post-edge state of one instance
    task automatic push(input string tag, input int dut, input int id, input bit to);
        exp_t e;
        e.dut = dut;
        e.id  = id[1:0];
        e.to  = to;
        case (dut)
            0:       e.busy = req_a[e.id];
            1:       e.busy = req_b[e.id];
            default: e.busy = req_c[e.id];
        endcase
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Advance one clock and check every queued expectation
    task automatic tick();
        exp_t       e;
        string      t;
        logic [3:0] og, eg;
        logic [1:0] oi;
        logic       ot, ob;
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            case (e.dut)
                0:       begin og = grant_a;          oi = id_a; ot = to_a; ob = busy_a; end
                1:       begin og = grant_b;          oi = id_b; ot = to_b; ob = busy_b; end
                default: begin og = {1'b0, grant_c}; oi = id_c; ot = to_c; ob = busy_c; end
            endcase
            eg = 4'b0001 << e.id;
            n_assert++;
            assert (oi === e.id) else begin
                n_fail++;
                $error("FAIL %s grant_id observed=%0d expected=%0d", t, oi, e.id);
            end
            n_assert++;
            assert (og === eg) else begin
                n_fail++;
                $error("FAIL %s grant observed=%b expected=%b", t, og, eg);
            end
            n_assert++;
            assert (ot === e.to) else begin
                n_fail++;
                $error("FAIL %s hold_timeout observed=%b expected=%b", t, ot, e.to);
            end
            n_assert++;
            assert (ob === e.busy) else begin
                n_fail++;
                $error("FAIL %s busy observed=%b expected=%b", t, ob, e.busy);
            end
            $display("step %s dut=%0d grant_id=%0d grant=%b hold_timeout=%b busy=%b",
                     t, e.dut, oi, og, ot, ob);
        end
    endtask

    task automatic run(input string tag, input int dut, input int id, input bit to);
        push(tag, dut, id, to);
        tick();
    endtask

    initial begin
        int seq_all[5] = '{0, 1, 2, 3, 0};
        int seq_alt[4] = '{1, 3, 1, 3};

        rst = 1'b1;
        req_a = '0; lock_a = '0;
        req_b = '0; lock_b = '0;
        req_c = '0; lock_c = '0;

        // Reset state on every instance
        push("rst_a", 0, 0, 0);
        push("rst_b", 1, 0, 0);
        push("rst_c", 2, 0, 0);
        tick();
        rst = 1'b0;

        // Idle bus parks on the reset owner
        for (int i = 0; i < 10; i++) run("park", 0, 0, 0);

        // Round-robin over all four, then over masters 1 and 3
        req_a = 4'b1111;
        for (int i = 0; i < 5; i++) run("rr_all", 0, seq_all[i], 0);
        req_a = 4'b1010;
        for (int i = 0; i < 4; i++) run("rr_alt", 0, seq_alt[i], 0);

        // Master 2 locked for 5 cycles: owns the bus 6 cycles, then RR resumes at 3
        for (int i = 0; i < 6; i++) begin
            req_a  = (i == 0) ? 4'b0100 : 4'b1111;
            lock_a = (i < 5)  ? 4'b0100 : 4'b0000;
            run("lock_hold", 0, 2, 0);
        end
        run("lock_rr", 0, 3, 0);
        run("lock_rr", 0, 0, 0);

        // Reset in the third HOLD cycle
        req_a = 4'b0010; lock_a = 4'b0010;
        run("mh_grant", 0, 1, 0);
        run("mh_hold", 0, 1, 0);
        run("mh_hold", 0, 1, 0);
        rst = 1'b1;
        run("mh_rst", 0, 0, 0);
        n_assert++;
        assert (dut_a.st_q === ST_ARB) else begin
            n_fail++;
            $error("FAIL mh_rst_st observed=%b expected=%b", dut_a.st_q, ST_ARB);
        end
        rst = 1'b0;
        req_a = '0; lock_a = '0;
        run("mh_after", 0, 0, 0);

        // Fixed priority: master 0 wins whenever it requests
        req_b = 4'b1110;
        run("fx_first", 1, 1, 0);
        req_b = 4'b1111;
        for (int i = 0; i < 3; i++) run("fx_m0", 1, 0, 0);
        req_b = 4'b1110;
        run("fx_m1", 1, 1, 0);
        // Owner lock alongside master 0 request: master 0 wins
        req_b = 4'b1111; lock_b = 4'b0010;
        run("fx_lockpri", 1, 0, 0);
        // Lock without request is ignored
        req_b = 4'b0000; lock_b = 4'b0100;
        run("fx_locknoreq", 1, 0, 0);
        n_assert++;
        assert (dut_b.st_q === ST_ARB) else begin
            n_fail++;
            $error("FAIL fx_locknoreq_st observed=%b expected=%b", dut_b.st_q, ST_ARB);
        end
        // Unlimited hold ignores higher-priority requests
        req_b = 4'b0100;
        run("fx_hold", 1, 2, 0);
        req_b = 4'b1111;
        for (int i = 0; i < 12; i++) run("fx_unl", 1, 2, 0);
        lock_b = 4'b0000;
        run("fx_rel", 1, 2, 0);
        run("fx_after", 1, 0, 0);

        // Timeout on the 3-master instance, MAX_HOLD=4
        req_c = 3'b010; lock_c = 3'b010;
        run("to_grant", 2, 1, 0);
        req_c = 3'b111;
        for (int i = 0; i < 3; i++) run("to_hold", 2, 1, 0);
        run("to_pulse", 2, 1, 1);
        run("to_next", 2, 2, 0);
        run("to_wrap", 2, 0, 0);
        run("to_regrant", 2, 1, 0);
        // Release and round-robin across three masters with wrap 2->0
        lock_c = 3'b000;
        run("rr3_rel", 2, 1, 0);
        run("rr3", 2, 2, 0);
        run("rr3", 2, 0, 0);
        run("rr3", 2, 1, 0);
        run("rr3", 2, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("FAIL watchdog time limit reached observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multi_bus_arbiter.md
# multi_bus_arbiter

Parametrised N-master bus arbiter for the AXI-side bus, successor to the two-master data/instruction arbiter. It selects one owner per cycle under fixed-priority or round-robin policy, holds ownership across locked bursts with an optional hold timeout, and parks the bus on the last owner when idle. Grants come straight from registered state and sit in front of the shared bus mux/AXI bridge.

## Interface
- NUM_MASTERS, 4: number of requesters, 2..16.
- RR_MODE, 1: 0 = fixed priority (index 0 highest), 1 = round-robin.
- MAX_HOLD, 16: maximum cycles a locked owner may keep the bus; 0 = unlimited.
- PARK_ID, 0: owner after reset.
- ID_W, derived: $clog2(NUM_MASTERS). Not overridable.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_MASTERS  per-master request level.
- lock  in  NUM_MASTERS  per-master burst lock. Only meaningful for the current owner.
- grant  out  NUM_MASTERS  one-hot grant, decoded from the owner register. Never all-zero.
- grant_id  out  ID_W  index of the current owner.
- busy  out  1  high when req[owner] is high.
- hold_timeout  out  1  one-cycle pulse when a hold is forcibly ended by MAX_HOLD.

## Operation
- State: owner (ID_W), rr_ptr (ID_W), st ∈ {ARB, HOLD}, hold_cnt (width to count MAX_HOLD, minimum 1 bit).
- Reset values:
  - owner=PARK_ID, rr_ptr=0, st=ARB, hold_cnt=0.
  - Outputs: grant=1<<PARK_ID, grant_id=PARK_ID, busy=req[PARK_ID], hold_timeout=0.
- ARB, with any req bit high: winner w is chosen and the following update:
  - owner<=w.
  - In RR_MODE, rr_ptr<=(w+1) mod NUM_MASTERS.
  - If lock[w] is high in the same cycle, st<=HOLD and hold_cnt<=1.
- Winner selection:
  - Fixed mode: lowest set index.
  - RR mode: first set index searching rr_ptr, rr_ptr+1, … with wrap past NUM_MASTERS-1 to 0.
- ARB, with req all-zero: owner, rr_ptr and st are unchanged (bus parks on last owner).
- HOLD:
  - Owner is frozen. Other requests are ignored.
  - Exit to ARB when lock[owner]==0 or req[owner]==0.
  - Also exit when MAX_HOLD!=0 and hold_cnt==MAX_HOLD. In this case hold_timeout=1 for that one cycle (registered, asserted the cycle after the decision), and rr_ptr<=(owner+1) mod N even in fixed mode, so the same master cannot immediately recapture.
  - Otherwise hold_cnt<=hold_cnt+1, saturating.
- Re-arbitration in the cycle HOLD exits: none. The first ARB cycle follows.
- Simultaneous events:
  - Fixed mode: master 0 request plus owner lock in ARB gives master 0 the win, because selection precedes lock evaluation.
  - Lock without req is ignored.
- Reset mid-hold: immediate return to the reset values above. No timeout pulse.
- NUM_MASTERS not a power of two: rr_ptr wraps explicitly at NUM_MASTERS-1, never reaching unused codes.

## Timing
- Request to grant: 1 cycle. req sampled at edge k gives grant valid after edge k, i.e. usable in cycle k+1.
- Grant change to bus: combinational decode of the owner flop only. No input-to-output combinational path except busy.
- Minimum ownership: 1 cycle. The owner can change every cycle in ARB.
- Locked burst of L cycles: owner is stable for L+1 cycles (grant cycle plus hold), capped at MAX_HOLD+1.
- hold_timeout is high exactly one cycle, the first ARB cycle after the forced release.

## Structure
- Shared package arb_pkg holds:
  - the ARB/HOLD state encoding;
  - the RR_MODE constants ARB_FIXED=0 and ARB_RR=1;
  - a function for the minimum-1 $clog2.
- One sub-module is natural: arb_rr_pick, a combinational rotate-priority-encoder taking req, rr_ptr and a mode bit and returning the winner index plus an any-request flag. It is reused by the fixed mode with ptr=0.
- The top level holds the owner, pointer, state and counter registers.

## Test plan
- Reset with req=0000: grant=0001, grant_id=0, busy=0, hold_timeout=0. Holding req=0000 for 10 cycles leaves grant unchanged (park).
- RR_MODE=1, req=1111 held, lock=0: grant_id sequence is 0,1,2,3,0 on consecutive cycles. With req=1010 the sequence is 1,3,1,3.
- RR_MODE=0, req=1110, then req=1111 one cycle later: grant_id=1, then 0. Master 0 always wins while it is set.
- Lock: master 2 wins with lock[2]=1 for 5 cycles while req=1111. grant_id=2 for 6 cycles, then round-robin resumes at 3.
- Timeout with MAX_HOLD=4: master 1 holds lock and req indefinitely. Ownership lasts 5 cycles, hold_timeout pulses once, next owner is 2 if requesting, else master 1 is regranted only after the others.
- rst asserted in the third HOLD cycle: the next cycle shows grant=1<<PARK_ID, st=ARB and no hold_timeout. NUM_MASTERS=3 round-robin wraps 2→0.
